// File: rtl/im_arb.sv
// rtl/im_arb.sv - two-port round-robin arbiter in front of a single-port instruction memory.
// Optional misaligned-access flag is enabled with macro IM_ARB_ALIGN_CHK_EN.
module im_arb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_data,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_data,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_dout,
    output logic              err
);

    logic              last_gnt_q, last_gnt_d;
    logic              owner_q, owner_d;
    logic              a_vld_q, a_vld_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic              f_valid_q, f_valid_d;
    logic [DATA_W-1:0] f_data_q, f_data_d;
    logic              d_valid_q, d_valid_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    logic              f_gnt_w, d_gnt_w, accept_w;
    logic [ADDR_W-1:0] gnt_addr_w;

    // Under contention the port that did not win last time is served.
    always_comb begin
        f_gnt_w    = rst_n & f_req & (~d_req | last_gnt_q);
        d_gnt_w    = rst_n & d_req & (~f_req | ~last_gnt_q);
        accept_w   = f_gnt_w | d_gnt_w;
        gnt_addr_w = d_gnt_w ? d_addr : f_addr;
    end

    assign f_gnt = f_gnt_w;
    assign d_gnt = d_gnt_w;

    always_comb begin
        last_gnt_d = accept_w ? d_gnt_w : last_gnt_q;
        owner_d    = accept_w ? d_gnt_w : owner_q;
        a_vld_d    = accept_w;
        im_addr_d  = accept_w ? gnt_addr_w : im_addr_q;
        f_valid_d  = a_vld_q & ~owner_q;
        d_valid_d  = a_vld_q & owner_q;
        f_data_d   = f_valid_d ? im_dout : f_data_q;
        d_data_d   = d_valid_d ? im_dout : d_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            a_vld_q    <= 1'b0;
            im_addr_q  <= '0;
            f_valid_q  <= 1'b0;
            f_data_q   <= '0;
            d_valid_q  <= 1'b0;
            d_data_q   <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            a_vld_q    <= a_vld_d;
            im_addr_q  <= im_addr_d;
            f_valid_q  <= f_valid_d;
            f_data_q   <= f_data_d;
            d_valid_q  <= d_valid_d;
            d_data_q   <= d_data_d;
        end
    end

    assign im_addr = im_addr_q;
    assign f_valid = f_valid_q;
    assign f_data  = f_data_q;
    assign d_valid = d_valid_q;
    assign d_data  = d_data_q;

`ifdef IM_ARB_ALIGN_CHK_EN
    // The misalignment bit travels alongside a_vld so err lines up with the valid pulse.
    logic mis_q, mis_d;
    logic err_q, err_d;

    always_comb begin
        mis_d = accept_w & (gnt_addr_w[1:0] != 2'b00);
        err_d = a_vld_q & mis_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_im_arb.sv
// tb/tb_im_arb.sv - scoreboard bench for im_arb with directed and random traffic.
module tb_im_arb;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              f_req = 1'b0, d_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0, d_addr = '0;
    logic              f_gnt, d_gnt, f_valid, d_valid, err;
    logic [DATA_W-1:0] f_data, d_data, im_dout;
    logic [ADDR_W-1:0] im_addr;

    im_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_valid(d_valid), .d_data(d_data),
        .im_addr(im_addr), .im_dout(im_dout), .err(err)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h00010203 + i * 32'h04040404;
    assign im_dout = mem[im_addr[ADDR_W-1:2]];

    typedef struct {
        bit              port;
        logic [DATA_W-1:0] data;
        bit              err;
        int              due;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0, cyc = 0;
    bit   m_last = 1'b1;
    bit   f_took = 1'b0, d_took = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit exp_err(logic [ADDR_W-1:0] a);
`ifdef IM_ARB_ALIGN_CHK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: reference arbitration, scoreboard push on acceptance, pop on valid.
    always @(negedge clk) begin
        bit   ef, ed;
        exp_t e;
        logic [ADDR_W-1:0] a;
        cyc++;
        if (!rst_n) begin
            m_last = 1'b1;
            q.delete();
            f_took = 1'b0;
            d_took = 1'b0;
            check("rst_f_gnt", f_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_im_addr", im_addr, 0);
            check("rst_f_valid", f_valid, 0);
            check("rst_d_valid", d_valid, 0);
            check("rst_f_data", f_data, 0);
            check("rst_d_data", d_data, 0);
            check("rst_err", err, 0);
        end else begin
            ef = f_req && (!d_req || m_last);
            ed = d_req && (!f_req || !m_last);
            check("f_gnt", f_gnt, ef);
            check("d_gnt", d_gnt, ed);
            f_took = f_req && f_gnt;
            d_took = d_req && d_gnt;
            if (ef || ed) begin
                a      = ed ? d_addr : f_addr;
                e.port = ed;
                e.data = 32'h00010203 + (a / 4) * 32'h04040404;
                e.err  = exp_err(a);
                e.due  = cyc + 2;
                q.push_back(e);
                m_last = ed;
            end
            check("valid_exclusive", f_valid & d_valid, 0);
            if (f_valid || d_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", {f_valid, d_valid}, 0);
                end else begin
                    e = q.pop_front();
                    check("resp_port", d_valid, e.port);
                    check("resp_data", e.port ? d_data : f_data, e.data);
                    check("resp_err", err, e.err);
                    check("resp_latency", cyc, e.due);
                end
            end else begin
                check("idle_err", err, 0);
                if (q.size() != 0 && q[0].due <= cyc) begin
                    e = q.pop_front();
                    check("missing_valid_due", cyc, e.due - 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, budget;
        do_reset();

        // Sequential fetch of words 0..9
        f_req = 1'b1; f_addr = '0; n = 0; budget = 0;
        while (n < 10 && budget < 100) begin
            step(); budget++;
            if (f_took) begin n++; f_addr = ADDR_W'(4 * n); end
        end
        f_req = 1'b0;
        check("seq_fetch_count", n, 10);
        repeat (5) step();

        // Contention from reset: f first, then alternating
        rst_n = 1'b0;
        f_req = 1'b1; f_addr = ADDR_W'(0);
        d_req = 1'b1; d_addr = ADDR_W'(8);
        repeat (3) step();
        rst_n = 1'b1;
        n = 0; budget = 0;
        while (n < 8 && budget < 100) begin
            step(); budget++;
            if (f_took || d_took) n++;
        end
        f_req = 1'b0; d_req = 1'b0;
        check("contention_count", n, 8);
        repeat (5) step();

        // Single debug request
        d_req = 1'b1; d_addr = ADDR_W'(12);
        step();
        check("debug_single_took", d_took, 1);
        d_req = 1'b0;
        repeat (5) step();

        // Reset between acceptance and data return
        f_req = 1'b1; f_addr = ADDR_W'(4);
        step();
        check("reset_case_took", f_took, 1);
        f_req = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (6) step();

        // Misaligned then aligned fetch
        f_req = 1'b1; f_addr = ADDR_W'(6);
        step();
        f_addr = ADDR_W'(8);
        step();
        f_req = 1'b0;
        repeat (5) step();

        // Random traffic, requesters hold until accepted
        for (int c = 0; c < 3000; c++) begin
            if (!f_req || f_took) begin
                f_req  = ($urandom_range(0, 9) < 6);
                f_addr = ADDR_W'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) != 0) f_addr[1:0] = 2'b00;
            end
            if (!d_req || d_took) begin
                d_req  = ($urandom_range(0, 9) < 5);
                d_addr = ADDR_W'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) != 0) d_addr[1:0] = 2'b00;
            end
            step();
        end
        f_req = 1'b0; d_req = 1'b0;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/im_arb.md
IM_ARB -- requirements
Module: im_arb

Interface
REQ-001 Parameter ADDR_W, default 10, IM byte-address width (im_1k: 1 KB).
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 f_req  input  1  fetch requester (port 0) read request.
REQ-006 f_addr  input  ADDR_W  fetch byte address.
REQ-007 f_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-008 f_valid  output  1  fetch read data valid (registered, one-cycle pulse per accepted request).
REQ-009 f_data  output  DATA_W  fetch read data.
REQ-010 d_req, d_addr, d_gnt, d_valid, d_data  same directions/widths/meanings as REQ-005..009, for the debug/loader requester (port 1).
REQ-011 im_addr  output  ADDR_W  registered address driven to im_1k addr.
REQ-012 im_dout  input  DATA_W  im_1k dout, combinational function of im_addr.
REQ-013 err  output  1  registered misaligned-access flag (see Configuration).

Function
REQ-014 Handshake: a request is accepted on a rising edge where req and gnt are both 1; requester holds req and addr stable until accepted.
REQ-015 At most one of f_gnt/d_gnt is 1 in any cycle; gnt is 0 whenever the corresponding req is 0.
REQ-016 Arbitration is round-robin: pointer last_gnt (1 bit) records the port of the most recent accepted request; when both request, the port other than last_gnt is granted; a single requester is granted unconditionally.
REQ-017 last_gnt updates only on an accepted request.
REQ-018 Pipeline stage A (acceptance edge): im_addr <= granted addr, owner <= granted port, a_vld <= 1; with no acceptance, a_vld <= 0 and im_addr holds.
REQ-019 Pipeline stage B (next edge): if a_vld, owner's data <= im_dout and owner's valid <= 1; the other port's valid <= 0 and its data holds.
REQ-020 Latency: valid rises exactly 2 rising edges after the acceptance edge, i.e. in the cycle after im_addr is updated.
REQ-021 Throughput: one acceptance per cycle sustained, back-to-back, alternating ports under contention, no bubbles.
REQ-022 Responses return in acceptance order; f_valid and d_valid are never both 1.
REQ-023 Address passes through unmodified (byte address, no wrap logic); addr values beyond the IM size are the IM's concern.

Reset
REQ-024 While rst_n = 0: im_addr = 0, f_data = d_data = 0, f_valid = d_valid = 0, err = 0, a_vld = 0, owner = 0, last_gnt = 1 (port 0 wins the first contention).
REQ-025 gnt outputs are forced to 0 while rst_n = 0.
REQ-026 Reset asserted mid-operation discards any in-flight request; no valid is produced for it after release.

Configuration
REQ-027 Macro IM_ARB_ALIGN_CHK_EN defined: an accepted request with addr[1:0] != 0 still gets its normal valid/data response, and err is 1 in that same valid cycle (0 otherwise).
REQ-028 Macro not defined: no alignment check is performed, and err is tied to 0.

Verification
REQ-029 IM loaded with word i = 32'h00010203 + i*32'h04040404; f_req with f_addr 0,4,...,36 held each cycle -> f_gnt every cycle, f_valid 10 consecutive cycles with data 00010203, 04050607, ..., 2425_2627.
REQ-030 f_req and d_req both held from reset, f_addr=0, d_addr=8 -> grants in order f,d,f,d...; valid data alternates 00010203 / 08090A0B.
REQ-031 d_req alone, d_addr=12, one cycle -> d_gnt=1, d_valid 2 edges later with 0C0D0E0F, f_valid stays 0.
REQ-032 Accept f_addr=4, assert rst_n=0 before stage B edge -> f_valid stays 0 through reset and after release; all outputs at REQ-024 values.
REQ-033 With IM_ARB_ALIGN_CHK_EN, f_addr=6 -> f_valid=1 with err=1 same cycle; f_addr=8 next -> err=0; without the macro, err stays 0 throughout.
